// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the multicycle controller and its datapath.
//   master : controller side (takes opcode/zero/mem_ready, drives controls)
//   slave  : datapath side (drives opcode/zero/mem_ready, takes controls)
// Signals:
//   opcode[5:0], zero, mem_ready              datapath -> controller
//   pc_write, i_or_d, mem_read, mem_write,
//   ir_write, mem_to_reg, reg_dst, reg_write,
//   alu_src_a, alu_src_b[1:0], alu_op[1:0],
//   pc_source[1:0], state_out[3:0], illegal_op controller -> datapath
// -----------------------------------------------------------------------------
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state_out;
  logic       illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state_out, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state_out, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a classic multicycle MIPS datapath
// (LW, SW, R-type, BEQ, J). Memory states can stall on mem_ready.
// Parameters:
//   MEM_WAIT_EN  1: FETCH/MEM_READ/MEM_WRITE wait for mem_ready
//                0: mem_ready ignored (treated as always ready)
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; forces FETCH and all outputs to 0
//   bus    multicycle_control_if.master (opcode/zero/mem_ready in,
//          datapath controls, state_out and illegal_op out)
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
  } state_t;

  // Full control word; one field per datapath control output.
  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(16'h0000);

  // True for the opcodes this controller knows how to sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

  // First state after DECODE for a given opcode; unknown opcodes go back to FETCH.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t target;
    case (op)
      OP_LW, OP_SW: target = MEM_ADDR;
      OP_RTYPE:     target = EXECUTE;
      OP_BEQ:       target = BRANCH;
      OP_J:         target = JUMP;
      default:      target = FETCH;
    endcase
    return target;
  endfunction

  state_t     state_r;
  state_t     next_s;
  logic [5:0] op_r;
  logic       ready_s;
  ctrl_t      ctrl_s;
  ctrl_t      out_s;

  // With waits disabled the memory is assumed to always complete in one cycle.
  assign ready_s = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Opcode capture in DECODE; MEM_ADDR routes on this copy because the
  // instruction register input may already be changing by then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r <= 6'd0;
    end else if (state_r == DECODE) begin
      op_r <= bus.opcode;
    end else begin
      op_r <= op_r;
    end
  end

  // Next-state and control decode.
  always_comb begin
    next_s = state_r;
    ctrl_s = CTRL_IDLE;
    case (state_r)
      FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_b = 2'b01;
        ctrl_s.alu_op    = 2'b00;
        ctrl_s.pc_source = 2'b00;
        if (ready_s) begin
          // Instruction arrives this cycle: latch it and bump PC together.
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
          next_s          = DECODE;
        end else begin
          next_s = FETCH;
        end
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        ctrl_s.alu_src_b = 2'b11;
        ctrl_s.alu_op    = 2'b00;
        if (is_legal_op(bus.opcode)) begin
          next_s = decode_target(bus.opcode);
        end else begin
          ctrl_s.illegal_op = 1'b1;
          next_s            = FETCH;
        end
      end
      MEM_ADDR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'b10;
        ctrl_s.alu_op    = 2'b00;
        if (op_r == OP_SW) begin
          next_s = MEM_WRITE;
        end else if (op_r == OP_LW) begin
          next_s = MEM_READ;
        end else begin
          next_s = FETCH;
        end
      end
      MEM_READ: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.i_or_d   = 1'b1;
        if (ready_s) begin
          next_s = MEM_WB;
        end else begin
          next_s = MEM_READ;
        end
      end
      MEM_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_dst    = 1'b0;
        next_s            = FETCH;
      end
      MEM_WRITE: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.i_or_d    = 1'b1;
        if (ready_s) begin
          next_s = FETCH;
        end else begin
          next_s = MEM_WRITE;
        end
      end
      EXECUTE: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'b00;
        ctrl_s.alu_op    = 2'b10;
        next_s           = R_WB;
      end
      R_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.reg_dst    = 1'b1;
        ctrl_s.mem_to_reg = 1'b0;
        next_s            = FETCH;
      end
      BRANCH: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'b00;
        ctrl_s.alu_op    = 2'b01;
        ctrl_s.pc_source = 2'b01;
        ctrl_s.pc_write  = bus.zero;
        next_s           = FETCH;
      end
      JUMP: begin
        ctrl_s.pc_write  = 1'b1;
        ctrl_s.pc_source = 2'b10;
        next_s           = FETCH;
      end
      default: begin
        // Unused encodings 10-15: recover to FETCH with everything idle.
        ctrl_s = CTRL_IDLE;
        next_s = FETCH;
      end
    endcase
  end

  // Reset masks the control word immediately, without waiting for a clock,
  // so the FETCH defaults never leak out while reset is held.
  always_comb begin
    if (reset) begin
      out_s = CTRL_IDLE;
    end else begin
      out_s = ctrl_s;
    end
  end

  assign bus.pc_write   = out_s.pc_write;
  assign bus.i_or_d     = out_s.i_or_d;
  assign bus.mem_read   = out_s.mem_read;
  assign bus.mem_write  = out_s.mem_write;
  assign bus.ir_write   = out_s.ir_write;
  assign bus.mem_to_reg = out_s.mem_to_reg;
  assign bus.reg_dst    = out_s.reg_dst;
  assign bus.reg_write  = out_s.reg_write;
  assign bus.alu_src_a  = out_s.alu_src_a;
  assign bus.alu_src_b  = out_s.alu_src_b;
  assign bus.alu_op     = out_s.alu_op;
  assign bus.pc_source  = out_s.pc_source;
  assign bus.illegal_op = out_s.illegal_op;
  assign bus.state_out  = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboard bench for multicycle_control. Two instances: dut0 waits on
// mem_ready, dut1 ignores it. Each stimulus step drives one cycle's inputs
// just after the rising edge and queues the hand-computed state and control
// word for that cycle; a monitor pops and compares on every falling edge.
// Control word packing (bit 15 down to 0):
//   pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
//   reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0],
//   illegal_op
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  multicycle_control_if bus0 ();
  multicycle_control_if bus1 ();

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  multicycle_control #(.MEM_WAIT_EN(1'b0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b001111;

  localparam logic [3:0] S_FETCH = 4'd0, S_DEC = 4'd1, S_MADDR = 4'd2,
                         S_MREAD = 4'd3, S_MWB = 4'd4, S_MWRITE = 4'd5,
                         S_EXEC = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_JUMP = 4'd9;

  // Hand-derived control words.
  localparam logic [15:0] W_IDLE   = 16'h0000;
  localparam logic [15:0] W_FETCH  = 16'hA820; // pc_write, mem_read, ir_write, alu_src_b=01
  localparam logic [15:0] W_FWAIT  = 16'h2020; // mem_read, alu_src_b=01
  localparam logic [15:0] W_DEC    = 16'h0060; // alu_src_b=11
  localparam logic [15:0] W_ILL    = 16'h0061; // alu_src_b=11, illegal_op
  localparam logic [15:0] W_MADDR  = 16'h00C0; // alu_src_a, alu_src_b=10
  localparam logic [15:0] W_MREAD  = 16'h6000; // i_or_d, mem_read
  localparam logic [15:0] W_MWB    = 16'h0500; // mem_to_reg, reg_write
  localparam logic [15:0] W_MWRITE = 16'h5000; // i_or_d, mem_write
  localparam logic [15:0] W_EXEC   = 16'h0090; // alu_src_a, alu_op=10
  localparam logic [15:0] W_RWB    = 16'h0300; // reg_dst, reg_write
  localparam logic [15:0] W_BR_T   = 16'h808A; // pc_write, alu_src_a, alu_op=01, pc_source=01
  localparam logic [15:0] W_BR_N   = 16'h008A; // same without pc_write
  localparam logic [15:0] W_JUMP   = 16'h8004; // pc_write, pc_source=10

  typedef struct packed {
    logic        dut;
    logic [3:0]  st;
    logic [15:0] word;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  wire [15:0] act0 = {bus0.pc_write, bus0.i_or_d, bus0.mem_read, bus0.mem_write,
                      bus0.ir_write, bus0.mem_to_reg, bus0.reg_dst, bus0.reg_write,
                      bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op, bus0.pc_source,
                      bus0.illegal_op};
  wire [15:0] act1 = {bus1.pc_write, bus1.i_or_d, bus1.mem_read, bus1.mem_write,
                      bus1.ir_write, bus1.mem_to_reg, bus1.reg_dst, bus1.reg_write,
                      bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op, bus1.pc_source,
                      bus1.illegal_op};

  // Drive one cycle of inputs (both instances) and queue the expected result.
  task automatic step(input logic rst, input logic [5:0] op, input logic z,
                      input logic rdy, input logic d, input logic [3:0] st,
                      input logic [15:0] w, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    bus0.opcode    = op;
    bus0.zero      = z;
    bus0.mem_ready = rdy;
    bus1.opcode    = op;
    bus1.zero      = z;
    bus1.mem_ready = rdy;
    e.dut  = d;
    e.st   = st;
    e.word = w;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare the queued expectation against the selected instance.
  initial begin
    exp_t        e;
    string       t;
    logic [19:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        act = e.dut ? {bus1.state_out, act1} : {bus0.state_out, act0};
        n_cmp++;
        if (act !== {e.st, e.word}) begin
          n_bad++;
          $display("FAIL %s (dut%0d): got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                   t, e.dut, act[19:16], act[15:0], e.st, e.word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.opcode = 6'd0; bus0.zero = 1'b0; bus0.mem_ready = 1'b1;
    bus1.opcode = 6'd0; bus1.zero = 1'b0; bus1.mem_ready = 1'b1;

    // Reset held: FETCH outputs suppressed even with mem_ready high.
    step(1'b1, OP_R, 1'b0, 1'b1, 1'b0, S_FETCH, W_IDLE, "reset_hold_a");
    step(1'b1, OP_R, 1'b0, 1'b1, 1'b0, S_FETCH, W_IDLE, "reset_hold_b");

    // FETCH stalls while memory not ready, then LW with no waits (5 cycles).
    step(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, S_FETCH, W_FWAIT, "fetch_wait");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_FETCH, W_FETCH, "lw_fetch");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_DEC,   W_DEC,   "lw_decode");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_MADDR, W_MADDR, "lw_addr");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_MREAD, W_MREAD, "lw_read");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_MWB,   W_MWB,   "lw_wb");

    // SW; live opcode flips to LW after DECODE, routing must follow the
    // captured SW. Three wait cycles in MEM_WRITE (7 cycles total).
    step(1'b0, OP_SW, 1'b0, 1'b1, 1'b0, S_FETCH,  W_FETCH,  "sw_fetch");
    step(1'b0, OP_SW, 1'b0, 1'b1, 1'b0, S_DEC,    W_DEC,    "sw_decode");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_MADDR,  W_MADDR,  "sw_addr_live_lw");
    step(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, S_MWRITE, W_MWRITE, "sw_write_wait1");
    step(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, S_MWRITE, W_MWRITE, "sw_write_wait2");
    step(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, S_MWRITE, W_MWRITE, "sw_write_wait3");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_MWRITE, W_MWRITE, "sw_write_done");

    // R-type (4 cycles).
    step(1'b0, OP_R, 1'b0, 1'b1, 1'b0, S_FETCH, W_FETCH, "r_fetch");
    step(1'b0, OP_R, 1'b0, 1'b1, 1'b0, S_DEC,   W_DEC,   "r_decode");
    step(1'b0, OP_R, 1'b0, 1'b1, 1'b0, S_EXEC,  W_EXEC,  "r_exec");
    step(1'b0, OP_R, 1'b0, 1'b1, 1'b0, S_RWB,   W_RWB,   "r_wb");

    // BEQ taken, then not taken (3 cycles each).
    step(1'b0, OP_BEQ, 1'b1, 1'b1, 1'b0, S_FETCH, W_FETCH, "beq1_fetch");
    step(1'b0, OP_BEQ, 1'b1, 1'b1, 1'b0, S_DEC,   W_DEC,   "beq1_decode");
    step(1'b0, OP_BEQ, 1'b1, 1'b1, 1'b0, S_BR,    W_BR_T,  "beq1_taken");
    step(1'b0, OP_BEQ, 1'b0, 1'b1, 1'b0, S_FETCH, W_FETCH, "beq0_fetch");
    step(1'b0, OP_BEQ, 1'b0, 1'b1, 1'b0, S_DEC,   W_DEC,   "beq0_decode");
    step(1'b0, OP_BEQ, 1'b0, 1'b1, 1'b0, S_BR,    W_BR_N,  "beq0_not_taken");

    // Jump (3 cycles).
    step(1'b0, OP_J, 1'b0, 1'b1, 1'b0, S_FETCH, W_FETCH, "j_fetch");
    step(1'b0, OP_J, 1'b0, 1'b1, 1'b0, S_DEC,   W_DEC,   "j_decode");
    step(1'b0, OP_J, 1'b0, 1'b1, 1'b0, S_JUMP,  W_JUMP,  "j_jump");

    // Illegal opcode: one-cycle illegal_op pulse, back to FETCH.
    step(1'b0, OP_BAD, 1'b0, 1'b1, 1'b0, S_FETCH, W_FETCH, "ill_fetch");
    step(1'b0, OP_BAD, 1'b0, 1'b1, 1'b0, S_DEC,   W_ILL,   "ill_decode");
    step(1'b0, OP_LW,  1'b0, 1'b1, 1'b0, S_FETCH, W_FETCH, "ill_refetch");

    // LW with one wait in MEM_READ (6 cycles).
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_DEC,   W_DEC,   "lw2_decode");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_MADDR, W_MADDR, "lw2_addr");
    step(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, S_MREAD, W_MREAD, "lw2_read_wait");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_MREAD, W_MREAD, "lw2_read_done");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_MWB,   W_MWB,   "lw2_wb");

    // Reset asserted between edges while stalled in MEM_READ.
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_FETCH, W_FETCH, "lw3_fetch");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_DEC,   W_DEC,   "lw3_decode");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_MADDR, W_MADDR, "lw3_addr");
    step(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, S_MREAD, W_MREAD, "lw3_read_wait");
    step(1'b1, OP_LW, 1'b0, 1'b0, 1'b0, S_FETCH, W_IDLE,  "reset_mid_read");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_FETCH, W_FETCH, "post_reset_fetch");
    step(1'b0, OP_LW, 1'b0, 1'b1, 1'b0, S_DEC,   W_DEC,   "post_reset_decode");

    // dut1 (mem_ready ignored) with mem_ready held low: R-type then SW.
    step(1'b1, OP_R,  1'b0, 1'b0, 1'b1, S_FETCH,  W_IDLE,   "nw_reset");
    step(1'b0, OP_R,  1'b0, 1'b0, 1'b1, S_FETCH,  W_FETCH,  "nw_r_fetch");
    step(1'b0, OP_R,  1'b0, 1'b0, 1'b1, S_DEC,    W_DEC,    "nw_r_decode");
    step(1'b0, OP_R,  1'b0, 1'b0, 1'b1, S_EXEC,   W_EXEC,   "nw_r_exec");
    step(1'b0, OP_R,  1'b0, 1'b0, 1'b1, S_RWB,    W_RWB,    "nw_r_wb");
    step(1'b0, OP_SW, 1'b0, 1'b0, 1'b1, S_FETCH,  W_FETCH,  "nw_sw_fetch");
    step(1'b0, OP_SW, 1'b0, 1'b0, 1'b1, S_DEC,    W_DEC,    "nw_sw_decode");
    step(1'b0, OP_SW, 1'b0, 1'b0, 1'b1, S_MADDR,  W_MADDR,  "nw_sw_addr");
    step(1'b0, OP_SW, 1'b0, 1'b0, 1'b1, S_MWRITE, W_MWRITE, "nw_sw_write");
    step(1'b0, OP_SW, 1'b0, 1'b0, 1'b1, S_FETCH,  W_FETCH,  "nw_sw_done");

    // Let the monitor drain the queue, bounded to a few cycles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1: 1 = memory states wait on mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-007 SHALL have outputs, all 1 bit: pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-008 SHALL have outputs alu_src_b (2 bits), alu_op (2 bits; 00 add, 01 sub, 10 funct-decoded), and pc_source (2 bits; 00 ALU result, 01 ALUOut, 10 jump target).
REQ-009 SHALL have outputs state_out (4 bits, current state encoding) and illegal_op (1 bit).

Function
REQ-010 SHALL be a Moore FSM with a 4-bit state register and these encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9.
REQ-011 SHALL drive every output not listed for a state to 0.
REQ-012 SHALL drive in FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write=1 and pc_write=1 only when ready.
REQ-013 SHALL define ready as mem_ready when MEM_WAIT_EN=1, and as 1 when MEM_WAIT_EN=0.
REQ-014 SHALL hold FETCH while not ready and move to DECODE when ready.
REQ-015 SHALL drive in DECODE: alu_src_b=11, alu_op=00 (branch target precompute).
REQ-016 SHALL move from DECODE to: MEM_ADDR on opcode 100011 (LW) or 101011 (SW); EXECUTE on 000000 (R-type); BRANCH on 000100 (BEQ); JUMP on 000010 (J).
REQ-017 SHALL, on any other opcode in DECODE, return to FETCH and pulse illegal_op=1 for exactly that DECODE cycle.
REQ-018 SHALL drive in MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_READ for LW, MEM_WRITE for SW.
REQ-019 SHALL route MEM_ADDR using the opcode captured in DECODE, not the live opcode input.
REQ-020 SHALL drive in MEM_READ: mem_read=1, i_or_d=1; hold while not ready; then go to MEM_WB.
REQ-021 SHALL drive in MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then go to FETCH.
REQ-022 SHALL drive in MEM_WRITE: mem_write=1, i_or_d=1; hold while not ready; then go to FETCH.
REQ-023 SHALL drive in EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; then go to R_WB.
REQ-024 SHALL drive in R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then go to FETCH.
REQ-025 SHALL drive in BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero; then go to FETCH.
REQ-026 SHALL drive in JUMP: pc_write=1, pc_source=10; then go to FETCH.
REQ-027 SHALL give these zero-wait instruction lengths: LW 5 cycles, SW 4, R-type 4, BEQ 3, J 3.
REQ-028 SHALL add one cycle per wait cycle in FETCH, MEM_READ and MEM_WRITE.
REQ-029 SHALL, on any unused state encoding (10-15), go to FETCH on the next clock with all outputs 0.
REQ-030 SHALL never assert mem_read and mem_write in the same cycle, nor reg_write and mem_write in the same cycle.

Reset
REQ-031 SHALL, on reset asserted at any time, including mid-wait, immediately force state=FETCH and the captured opcode to 0, with no clock required.
REQ-032 SHALL, while reset is high, hold all outputs at 0 (FETCH outputs suppressed).
REQ-033 SHALL resume FETCH behaviour on the first clock edge after reset deasserts.

Verification
REQ-034 SHALL cover: LW opcode, mem_ready=1 constantly -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-035 SHALL cover: SW with mem_ready low for 3 cycles in MEM_WRITE -> mem_write high for 4 cycles, then FETCH; total 7 cycles.
REQ-036 SHALL cover: BEQ with zero=1, then BEQ with zero=0 -> pc_write=1 with pc_source=01 in BRANCH for the first only; 3 cycles each.
REQ-037 SHALL cover: opcode 001111 -> illegal_op=1 for one cycle in DECODE, then FETCH; reg_write and mem_write stay 0 throughout.
REQ-038 SHALL cover: reset pulsed mid-MEM_READ between clock edges -> state_out=0 and all outputs 0 before the next edge.
REQ-039 SHALL cover: MEM_WAIT_EN=0 with mem_ready=0 held -> R-type completes in 4 cycles (states 0,1,6,7).
